reg_dump_reader: RTL and testbench



---
 rtl/reg_dump_reader_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 138 +++++++++++++
 tb/tb_reg_dump_reader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared register-file constants and the dump reader state type.
package reg_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    CSUM  = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through one read port and streams them as valid/ready beats.
// Optional trailing XOR checksum beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = FIRST_REG[REG_ADDR_W-1:0];
  localparam logic [REG_ADDR_W-1:0] LAST_A  = LAST_REG[REG_ADDR_W-1:0];

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   ptr_q, ptr_d;
  logic [REG_ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [REG_DATA_W-1:0]   out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic                    handshake;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_DATA_W-1:0]   csum_q, csum_d;
`endif

  // Valid/busy decode straight from state so reset drops them without waiting for a clock.
  assign out_valid = (state_q == SEND) || (state_q == CSUM);
  assign busy      = (state_q != IDLE);
  assign handshake = out_valid && out_ready;
  assign done      = done_q;
  assign rd_addr   = ptr_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d      = FIRST_A;
          out_last_d = 1'b0;
          state_d    = FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      FETCH: begin
        out_addr_d = ptr_q;
        out_data_d = rd_data;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d = 1'b0;
`else
        out_last_d = (ptr_q == LAST_A);
`endif
        state_d    = SEND;
      end
      SEND: begin
        if (handshake) begin
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (ptr_q != LAST_A) begin
            ptr_d   = ptr_q + 5'd1;
            state_d = FETCH;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat is loaded directly; there is no register to fetch.
            out_addr_d = '0;
            out_data_d = csum_q ^ out_data_q;
            out_last_d = 1'b1;
            state_d    = CSUM;
`else
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (handshake) begin
          out_last_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= FIRST_A;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: full-range and 4..6 instances checked against a beat-queue model.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  start_i, ready_i, busy_o, done_o, valid_o, last_o;
  logic [4:0]  rd_addr_o [2];
  logic [4:0]  out_addr_o [2];
  logic [31:0] rd_data_i [2];
  logic [31:0] out_data_o [2];
  logic [31:0] rf0 [32];
  logic [31:0] rf1 [32];

  assign rd_data_i[0] = rf0[rd_addr_o[0]];
  assign rd_data_i[1] = rf1[rd_addr_o[1]];

  reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut_full (
    .clk(clk), .rst(rst), .start(start_i[0]), .busy(busy_o[0]), .done(done_o[0]),
    .rd_addr(rd_addr_o[0]), .rd_data(rd_data_i[0]), .out_valid(valid_o[0]),
    .out_ready(ready_i[0]), .out_addr(out_addr_o[0]), .out_data(out_data_o[0]),
    .out_last(last_o[0])
  );

  reg_dump_reader #(.FIRST_REG(4), .LAST_REG(6)) dut_part (
    .clk(clk), .rst(rst), .start(start_i[1]), .busy(busy_o[1]), .done(done_o[1]),
    .rd_addr(rd_addr_o[1]), .rd_data(rd_data_i[1]), .out_valid(valid_o[1]),
    .out_ready(ready_i[1]), .out_addr(out_addr_o[1]), .out_data(out_data_o[1]),
    .out_last(last_o[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: on an accepted start, queue every beat the dump must produce; pop on handshake.
  logic [37:0] exp_mem [2][64];
  int          head [2];
  int          tail [2];
  bit          m_active [2];
  bit          m_done_due [2];
  int          cyc = 0;
  int          start_cyc [2];
  int          done_rel [2];
  int          done_cnt [2];
  int          beat_cnt [2];
  logic [4:0]  first_addr [2];
  logic [31:0] seen_data [2][32];
  int          lane_first [2] = '{0, 4};
  int          lane_last [2]  = '{31, 6};

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        head[k] = 0; tail[k] = 0; m_active[k] = 1'b0; m_done_due[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit          was_active;
        bit          nd;
        logic [37:0] e;
        logic [31:0] cs;
        logic [31:0] d;
        check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_active[k]));
        check($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done_due[k]));
        if (done_o[k]) begin
          done_cnt[k]++;
          done_rel[k] = cyc - start_cyc[k];
        end
        if (valid_o[k]) begin
          if (head[k] == tail[k]) begin
            check($sformatf("unexpected_beat%0d", k), 32'(valid_o[k]), 32'd0);
          end else begin
            e = exp_mem[k][head[k]];
            check($sformatf("addr%0d", k), 32'(out_addr_o[k]), 32'(e[36:32]));
            check($sformatf("data%0d", k), out_data_o[k], e[31:0]);
            check($sformatf("last%0d", k), 32'(last_o[k]), 32'(e[37]));
          end
        end else if (!m_active[k]) begin
          check($sformatf("valid_idle%0d", k), 32'(valid_o[k]), 32'd0);
        end
        was_active = m_active[k];
        nd = 1'b0;
        if (valid_o[k] && ready_i[k] && head[k] != tail[k]) begin
          seen_data[k][out_addr_o[k]] = out_data_o[k];
          if (beat_cnt[k] == 0) first_addr[k] = out_addr_o[k];
          beat_cnt[k]++;
          head[k]++;
          if (head[k] == tail[k]) begin
            nd = 1'b1;
            m_active[k] = 1'b0;
          end
        end
        if (start_i[k] && !was_active) begin
          head[k] = 0; tail[k] = 0; cs = '0;
          for (int r = lane_first[k]; r <= lane_last[k]; r++) begin
            d = (k == 0) ? rf0[r] : rf1[r];
            exp_mem[k][tail[k]] = {(r == lane_last[k]) && !CSUM_ON, 5'(r), d};
            tail[k]++;
            cs ^= d;
          end
          if (CSUM_ON) begin
            exp_mem[k][tail[k]] = {1'b1, 5'd0, cs};
            tail[k]++;
          end
          m_active[k]  = 1'b1;
          start_cyc[k] = cyc;
          beat_cnt[k]  = 0;
        end
        m_done_due[k] = nd;
      end
    end
  end

  task automatic pulse_start(input int k);
    @(posedge clk); #1 start_i[k] = 1'b1;
    @(posedge clk); #1 start_i[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    forever begin
      @(posedge clk); #1;
      if (done_o[k]) break;
      n++;
      if (n > budget) begin
        check($sformatf("done_timeout%0d", k), 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic wait_beat(input int k, input logic [4:0] a, input int budget);
    int n = 0;
    while (!(valid_o[k] && out_addr_o[k] == a)) begin
      @(posedge clk); #1;
      n++;
      if (n > budget) begin
        check($sformatf("beat_timeout%0d", k), 32'(out_addr_o[k]), 32'(a));
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf0[i] = '0; rf1[i] = '0;
      seen_data[0][i] = 'x; seen_data[1][i] = 'x;
    end
    rf0[25] = 32'h0000_000A;
    rf1[4] = 32'h11; rf1[5] = 32'h22; rf1[6] = 32'h33;
    start_i = '0; ready_i = 2'b11;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0; beat_cnt[k] = 0; done_rel[k] = 0; start_cyc[k] = 0; first_addr[k] = '0;
    end

    // Reset values
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_last", 32'(last_o), 32'd0);
    check("rst_out_addr0", 32'(out_addr_o[0]), 32'd0);
    check("rst_out_data0", out_data_o[0], 32'd0);
    check("rst_rd_addr0", 32'(rd_addr_o[0]), 32'd0);
    check("rst_rd_addr1", 32'(rd_addr_o[1]), 32'd4);
    @(posedge clk); #1 rst = 1'b0;

    // Full dump, ready always high
    pulse_start(0);
    wait_done(0, 200);
    $display("full dump: beats=%0d done_cycle=%0d", beat_cnt[0], done_rel[0]);
    check("full_done_cycle", 32'(done_rel[0]), CSUM_ON ? 32'd66 : 32'd65);
    check("full_beats", 32'(beat_cnt[0]), CSUM_ON ? 32'd33 : 32'd32);
    check("full_reg25", seen_data[0][25], 32'h0000_000A);
    check("full_reg24", seen_data[0][24], 32'h0);
    check("full_first_addr", 32'(first_addr[0]), 32'd0);
    check("full_done_cnt", 32'(done_cnt[0]), 32'd1);

    // Stall five cycles on beat 3
    pulse_start(0);
    wait_beat(0, 5'd3, 40);
    ready_i[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(valid_o[0]), 32'd1);
      check("stall_addr", 32'(out_addr_o[0]), 32'd3);
      check("stall_data", out_data_o[0], 32'd0);
      $display("stall cycle %0d: addr=%0d data=0x%08h", i, out_addr_o[0], out_data_o[0]);
      @(posedge clk); #1;
    end
    ready_i[0] = 1'b1;
    wait_done(0, 200);
    check("stall_beats", 32'(beat_cnt[0]), CSUM_ON ? 32'd33 : 32'd32);
    check("stall_done_cnt", 32'(done_cnt[0]), 32'd2);

    // Partial range 4..6
    pulse_start(1);
    wait_done(1, 50);
    $display("partial dump: beats=%0d done_cycle=%0d", beat_cnt[1], done_rel[1]);
    check("part_done_cycle", 32'(done_rel[1]), CSUM_ON ? 32'd8 : 32'd7);
    check("part_beats", 32'(beat_cnt[1]), CSUM_ON ? 32'd4 : 32'd3);
    check("part_first_addr", 32'(first_addr[1]), 32'd4);
    check("part_reg5", seen_data[1][5], 32'h22);
    check("part_reg6", seen_data[1][6], 32'h33);

    // Second start at cycle 10 of a dump is ignored
    pulse_start(0);
    repeat (8) @(posedge clk);
    pulse_start(0);
    wait_done(0, 200);
    repeat (4) @(posedge clk);
    #1;
    $display("restart-ignored dump: beats=%0d done_cycle=%0d", beat_cnt[0], done_rel[0]);
    check("ignore_done_cycle", 32'(done_rel[0]), CSUM_ON ? 32'd66 : 32'd65);
    check("ignore_done_cnt", 32'(done_cnt[0]), 32'd3);
    check("ignore_busy", 32'(busy_o[0]), 32'd0);

    // Reset while beat 12 is offered
    pulse_start(0);
    wait_beat(0, 5'd12, 60);
    #1 rst = 1'b1;
    #1;
    $display("reset mid-dump: valid=%0d busy=%0d", valid_o[0], busy_o[0]);
    check("rst_mid_valid", 32'(valid_o[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_o[0]), 32'd0);
    check("rst_mid_done", 32'(done_o[0]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt[0]), 32'd3);
    pulse_start(0);
    wait_done(0, 200);
    check("after_rst_first_addr", 32'(first_addr[0]), 32'd0);
    check("after_rst_beats", 32'(beat_cnt[0]), CSUM_ON ? 32'd33 : 32'd32);
    check("after_rst_done_cnt", 32'(done_cnt[0]), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
